// File: rtl/text_line_overlay.sv
// Single-line text overlay: maps the beam position onto a character line buffer,
// drives the glyph ROM, and returns a blinking-cursor-aware pixel two clocks later.
module text_line_overlay #(
   parameter int N_CHARS      = 16,
   parameter int AW           = 4,
   parameter int X0           = 0,
   parameter int Y0           = 0,
   parameter int SCALE_LOG2   = 1,
   parameter int BLINK_FRAMES = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [10:0]   hc,
   input  logic [10:0]   vc,
   input  logic          de,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          cursor_en,
   input  logic [AW-1:0] cursor_pos,
   output logic [7:0]    sel,
   output logic [2:0]    coor_x,
   output logic [2:0]    coor_y,
   input  logic          glyph_pixel,
   output logic          pixel_out,
   output logic          pixel_valid
);

   localparam int unsigned X_LO    = X0;
   localparam int unsigned Y_LO    = Y0;
   localparam int unsigned X_END   = X0 + ((N_CHARS * 8) << SCALE_LOG2);
   localparam int unsigned Y_END   = Y0 + (8 << SCALE_LOG2);
   localparam int unsigned N_CELLS = N_CHARS;
   localparam logic [10:0] X_OFF   = 11'(X0);
   localparam logic [10:0] Y_OFF   = 11'(Y0);
   localparam int          CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [7:0]  SPACE   = 8'h20;

   logic [10:0]      rx;
   logic [10:0]      ry;
   logic [AW-1:0]    idx;
   logic [2:0]       gx;
   logic [2:0]       gy;
   logic             in_box;
   logic             cur_hit;
   logic             wr_ok;
   logic             at_origin;
   logic             prev_origin;
   logic             frame_tick;

   logic [7:0]       line_buf [N_CHARS];
   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;

   logic             s1_box;
   logic             s1_gap;
   logic             s1_cur;
   logic             s1_de;

   always_comb begin
      rx         = hc - X_OFF;
      ry         = vc - Y_OFF;
      in_box     = (32'(hc) >= X_LO) && (32'(hc) < X_END) &&
                   (32'(vc) >= Y_LO) && (32'(vc) < Y_END);
      idx        = AW'(rx >> (3 + SCALE_LOG2));
      gx         = 3'(rx >> SCALE_LOG2);
      gy         = 3'(ry >> SCALE_LOG2);
      cur_hit    = (32'(cursor_pos) < N_CELLS) && (cursor_pos == idx);
      wr_ok      = wr_en && (32'(wr_addr) < N_CELLS);
      at_origin  = (hc == 11'd0) && (vc == 11'd0);
      frame_tick = at_origin && !prev_origin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CHARS; i++) line_buf[i] <= SPACE;
      end else if (wr_ok) begin
         line_buf[wr_addr] <= wr_data;
      end
   end

   // Tracks the beam even during reset, so a generator parked at (0,0)
   // across reset release does not produce a spurious frame tick.
   always_ff @(posedge clk) begin
      prev_origin <= at_origin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel    <= SPACE;
         coor_x <= 3'd0;
         coor_y <= 3'd0;
         s1_box <= 1'b0;
         s1_gap <= 1'b0;
         s1_cur <= 1'b0;
         s1_de  <= 1'b0;
      end else begin
         sel    <= in_box ? line_buf[idx] : SPACE;
         coor_x <= (gx < 3'd5) ? gx : 3'd0;
         coor_y <= gy;
         s1_box <= in_box & de;
         s1_gap <= (gx >= 3'd5);
         s1_cur <= cursor_en & blink_phase & cur_hit;
         s1_de  <= de;
      end
   end

   // Spacing columns carry no ink, but the cursor still inverts them.
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_out   <= 1'b0;
         pixel_valid <= 1'b0;
      end else begin
         pixel_out   <= s1_box & ((glyph_pixel & ~s1_gap) ^ s1_cur);
         pixel_valid <= s1_de;
      end
   end

endmodule

// File: doc/text_line_overlay.md
Name: text_line_overlay

Overview:
- Text overlay controller that sequences the 5x8 glyph ROM (ASCII select, 3-bit column/row in, one pixel out) for a single line of text on a VGA-style raster.
- Holds an N_CHARS character line buffer, written by a host port.
- Takes the beam position (hc/vc), drives the ROM's select/coordinates, and returns a registered overlay pixel two cycles later.
- Adds a blinking block cursor. Sits between the VGA timing generator and the colour mux.

Parameters:
- N_CHARS, 16, number of character cells in the line (power of 2, 2..64).
- AW, 4, buffer address width (log2 N_CHARS).
- X0, 0, left screen column of the text box.
- Y0, 0, top screen row of the text box.
- SCALE_LOG2, 1, each glyph pixel is drawn as (1<<SCALE_LOG2) x (1<<SCALE_LOG2) screen pixels.
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1).

Ports:
- clk  in  1  pixel clock; hc/vc advance at most once per clk.
- rst  in  1  synchronous, active-high reset.
- hc  in  11  beam column.
- vc  in  11  beam row.
- de  in  1  display-enable for the current hc/vc.
- wr_en  in  1  host write strobe.
- wr_addr  in  AW  buffer cell to write.
- wr_data  in  8  ASCII code to store.
- cursor_en  in  1  enables cursor rendering.
- cursor_pos  in  AW  cursor cell index.
- sel  out  8  character code to glyph ROM.
- coor_x  out  3  glyph column to ROM (0 = left).
- coor_y  out  3  glyph row to ROM (0 = top).
- glyph_pixel  in  1  ROM pixel for the current sel/coor_x/coor_y (combinational, same cycle).
- pixel_out  out  1  overlay pixel, aligned 2 cycles after hc/vc.
- pixel_valid  out  1  de delayed by 2 cycles.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - all buffer entries = 0x20 (space)
  - sel=0x20, coor_x=0, coor_y=0
  - pixel_out=0, pixel_valid=0
  - blink counter=0, blink_phase=0
  - all pipeline flags=0
- Geometry:
  - rx = hc - X0 and ry = vc - Y0, computed as 11-bit unsigned.
  - in_box when hc >= X0, hc < X0 + (N_CHARS*8 << SCALE_LOG2), vc >= Y0, vc < Y0 + (8 << SCALE_LOG2).
  - idx = rx >> (3+SCALE_LOG2), truncated to AW.
  - gx = (rx >> SCALE_LOG2) & 7.
  - gy = (ry >> SCALE_LOG2) & 7.
  - Each cell is 8 glyph columns wide: columns 0..4 come from the ROM, columns 5..7 are inter-character spacing.
- Stage 1 (registered at edge after hc/vc):
  - sel <= in_box ? buf[idx] : 0x20.
  - coor_x <= (gx<5) ? gx : 0.
  - coor_y <= gy.
  - Flags registered alongside: s1_box=in_box&de, s1_gap=(gx>=5), s1_cur=cursor_en & blink_phase & (idx==cursor_pos).
- Stage 2 (registered):
  - pixel_out <= s1_box & ((glyph_pixel & ~s1_gap) ^ s1_cur).
  - pixel_valid <= de delayed 2.
- Latency: exactly 2 clk from hc/vc to pixel_out; no bubbles, fully pipelined.
- Write port:
  - On wr_en, buf[wr_addr] <= wr_data at the clock edge.
  - wr_addr >= N_CHARS is ignored (only possible when N_CHARS < 2^AW).
  - A write and a stage-1 read of the same cell in the same cycle: the read returns the OLD value; the new value is visible from the next cycle.
  - Writes are accepted at any time, including during de.
- Blink:
  - frame_tick = (hc==0 && vc==0) on a cycle where the previous cycle's (hc,vc) was not (0,0). It is a single pulse even if the timing generator stalls at 0,0.
  - On frame_tick the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - The counter runs regardless of cursor_en.
- Cursor:
  - When visible, it inverts the whole 8x8 cell, spacing columns included, only inside the box.
  - cursor_pos >= N_CHARS never matches any cell.
- rst asserted mid-line: at the next edge, outputs go to reset values and the buffer is cleared. Pixels in flight are discarded (pixel_out=0 for the two cycles after reset release until new data propagates).

Test Plan:
- Reset then scan: assert rst 1 cycle, raster one full frame with default params. Required: pixel_out=0 everywhere (all spaces), pixel_valid == de delayed 2, sel=0x20 outside box.
- Glyph fetch and scaling: write cell 0 = "1" (0x31), X0=Y0=0, SCALE_LOG2=1. At hc=2..3, vc=0..1 (gx=1, gy=0), sel=0x31 and coor=(1,0) one cycle later; pixel_out=1 two cycles later. At hc=0, vc=0, pixel_out=0.
- Spacing columns: write cell 0 = "A" (0x41), row gy=3 (row pattern 11111). For hc=0..9 pixel_out=1; for hc=10..15 (gx 5..7) pixel_out=0 and coor_x=0.
- Write/read collision: hold hc in cell 3 and write 0x41 to addr 3 on the same cycle. sel shows the old value (0x20) that cycle and 0x41 on the next sample of cell 3.
- Cursor blink: BLINK_FRAMES=2, cursor_en=1, cursor_pos=5, empty buffer. Frames 0-1: cell 5 all 0. Frames 2-3: cell 5 (hc 80..95, vc 0..15) all 1 and cell 4 still 0. Frame 4: off. With cursor_en=0 nothing is drawn.
- Reset mid-frame: buffer holds "HELLO"; assert rst at hc=20, vc=5. Required: pixel_out=0 from the next edge onward, sel=0x20, and the following frame renders all spaces.
